ram_refill_ctrl: RTL and testbench

//  Memory-side controller directly downstream of the 2-way cache. Accepts one

---
 rtl/mem_hier_pkg.sv | 26 ++
 rtl/ram_array.sv | 31 +++
 rtl/ram_refill_ctrl.sv | 142 ++++++++++++++
 tb/tb_ram_refill_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_hier_pkg.sv
// Shared definitions for the memory hierarchy below the 2-way cache.
//  - Default line-address and data widths.
//  - Controller state encodings (IDLE, WB, FETCH, DONE, REARM).
//  - Bit positions inside the 3-bit request signature {hit_miss, is_write, wback}.
//  - needs_fetch(): decides whether a request requires a refill read.
package mem_hier_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WB    = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_REARM = 3'd4;

  localparam int SIG_HIT = 2;
  localparam int SIG_WR  = 1;
  localparam int SIG_WB  = 0;

  // Only a read miss brings a line back from RAM.
  function automatic logic needs_fetch(input logic hit, input logic is_write);
    return !hit && !is_write;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Backing RAM: 2^ADDR_W words of DATA_W bits, no reset on contents.
// Ports:
//  clock  in   system clock
//  we     in   write enable, write commits on the posedge where we=1
//  waddr  in   write address
//  wdata  in   write data
//  raddr  in   read address, sampled every posedge
//  rdata  out  registered read data (mem[raddr] as of the last posedge)
module ram_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write-first forwarding: a read of the address being written on the same
  // edge returns the new word, so a refill right after a write-back sees it.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_refill_ctrl.sv
// Memory-side controller behind the 2-way cache. Accepts one request per miss
// or write-back, performs an optional dirty-line write-back, an optional refill
// read, then pulses done for one cycle. Keeps saturating miss/write-back counts.
// Ports:
//  clock       in   system clock
//  reset_n     in   asynchronous active-low reset
//  req_n       in   active-low request level, held low while the cache waits
//  sig         in   {hit_miss, is_write, wback}
//  fetch_addr  in   line address to refill
//  wb_addr     in   dirty victim address
//  wb_data     in   dirty victim data
//  rd_data     out  refill word, valid while done=1 and held afterwards
//  done        out  one-cycle completion pulse
//  busy        out  high whenever the FSM is not in IDLE
//  miss_cnt    out  read misses serviced, saturating
//  wb_cnt      out  write-backs performed, saturating
module ram_refill_ctrl
  import mem_hier_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_n,
  input  logic [2:0]        sig,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] RD_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LAST = LAT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]        state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              fetch_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              armed;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // The write commits on the final WB cycle only, so a reset before that edge
  // leaves RAM untouched.
  assign ram_we = (state == ST_WB) && (lat_cnt == WR_LAST);

  // In IDLE the RAM already looks at the incoming address so its registered
  // output is valid from the first FETCH cycle, even with RD_LAT=1.
  assign ram_raddr = (state == ST_IDLE) ? fetch_addr : fetch_addr_q;

  assign busy = (state != ST_IDLE);

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(wb_addr_q),
    .wdata(wb_data_q),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Main FSM. done is registered from the DONE state, so it rises one edge
  // after the RAM work finishes. 'armed' blocks acceptance of a request that
  // was already held low across reset until req_n has been seen high once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      fetch_q      <= 1'b0;
      fetch_addr_q <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      armed        <= 1'b0;
      rd_data      <= '0;
      done         <= 1'b0;
      miss_cnt     <= '0;
      wb_cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (req_n) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!req_n && armed) begin
            fetch_q      <= needs_fetch(sig[SIG_HIT], sig[SIG_WR]);
            fetch_addr_q <= fetch_addr;
            wb_addr_q    <= wb_addr;
            wb_data_q    <= wb_data;
            lat_cnt      <= '0;
            if (sig[SIG_WB])                              state <= ST_WB;
            else if (needs_fetch(sig[SIG_HIT], sig[SIG_WR])) state <= ST_FETCH;
            else                                          state <= ST_REARM;
          end
        end
        ST_WB: begin
          if (lat_cnt == WR_LAST) begin
            lat_cnt <= '0;
            if (wb_cnt != CNT_MAX) wb_cnt <= wb_cnt + CNT_W'(1);
            state <= fetch_q ? ST_FETCH : ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ST_FETCH: begin
          if (lat_cnt == RD_LAST) begin
            lat_cnt <= '0;
            rd_data <= ram_rdata;
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_REARM;
        end
        ST_REARM: begin
          if (req_n) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_refill_ctrl.sv
// Directed self-checking bench for ram_refill_ctrl (default parameters) plus a
// second instance with CNT_W=2 sharing the same inputs for counter saturation.
module tb_ram_refill_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_n;
  logic [2:0] sig;
  logic [4:0] fetch_addr;
  logic [4:0] wb_addr;
  logic [2:0] wb_data;

  logic [2:0] rd_data;
  logic       done;
  logic       busy;
  logic [7:0] miss_cnt;
  logic [7:0] wb_cnt;

  logic [2:0] rd_data_s;
  logic       done_s;
  logic       busy_s;
  logic [1:0] miss_cnt_s;
  logic [1:0] wb_cnt_s;

  int tests = 0;
  int fails = 0;
  int fd;
  int nd;

  always #5 clock = ~clock;

  ram_refill_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_n     (req_n),
    .sig       (sig),
    .fetch_addr(fetch_addr),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_data   (rd_data),
    .done      (done),
    .busy      (busy),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
  );

  ram_refill_ctrl #(.CNT_W(2)) dut_sat (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_n     (req_n),
    .sig       (sig),
    .fetch_addr(fetch_addr),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_data   (rd_data_s),
    .done      (done_s),
    .busy      (busy_s),
    .miss_cnt  (miss_cnt_s),
    .wb_cnt    (wb_cnt_s)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request and hold req_n low for ncyc edges (edge 0 = accept edge),
  // recording the edge index of the first done pulse and the number of pulses.
  task automatic apply_stimulus(input logic [2:0] s, input logic [4:0] fa,
                                input logic [4:0] wa, input logic [2:0] wd,
                                input int ncyc);
    sig        = s;
    fetch_addr = fa;
    wb_addr    = wa;
    wb_data    = wd;
    req_n      = 1'b0;
    fd = -1;
    nd = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        nd++;
        if (fd < 0) fd = c;
      end
    end
  endtask

  task automatic release_req();
    req_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic do_op(input string tag, input logic [2:0] s, input logic [4:0] fa,
                       input logic [4:0] wa, input logic [2:0] wd, input int lat);
    apply_stimulus(s, fa, wa, wd, lat + 4);
    check_output({tag, "_latency"}, fd, lat);
    check_output({tag, "_pulses"}, nd, 1);
    release_req();
  endtask

  initial begin
    reset_n = 1'b0; req_n = 1'b1; sig = 3'b000;
    fetch_addr = 5'h00; wb_addr = 5'h00; wb_data = 3'b000;
    repeat (2) @(posedge clock); #1;
    check_output("reset_rd_data", rd_data, 0);
    check_output("reset_done", done, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_miss", miss_cnt, 0);
    check_output("reset_wb", wb_cnt, 0);
    check_output("reset_sat_outputs", {rd_data_s, done_s, busy_s, miss_cnt_s, wb_cnt_s}, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Preload RAM through write-back-only requests (hit with dirty victim).
    do_op("preload_0B", 3'b101, 5'h00, 5'h0B, 3'b110, 3);
    do_op("preload_0C", 3'b101, 5'h00, 5'h0C, 3'b010, 3);

    // Read miss clean: done after edge RD_LAT+1.
    do_op("clean_read", 3'b000, 5'h0B, 5'h00, 3'b000, 3);
    check_output("clean_read_data", rd_data, 3'b110);
    check_output("clean_read_miss", miss_cnt, 1);
    check_output("clean_read_wb", wb_cnt, 2);

    // Read miss dirty to the same line: refill must see the written data.
    do_op("dirty_read", 3'b001, 5'h0C, 5'h0C, 3'b101, 5);
    check_output("dirty_read_data", rd_data, 3'b101);
    check_output("dirty_read_miss", miss_cnt, 2);
    check_output("dirty_read_wb", wb_cnt, 3);
    do_op("verify_0C", 3'b000, 5'h0C, 5'h00, 3'b000, 3);
    check_output("verify_0C_data", rd_data, 3'b101);

    // Hit without write-back: no RAM work, no done, stuck in REARM.
    apply_stimulus(3'b100, 5'h0B, 5'h00, 3'b000, 10);
    check_output("hit_nowb_pulses", nd, 0);
    check_output("hit_nowb_busy", busy, 1);
    check_output("hit_nowb_counts", {miss_cnt, wb_cnt}, {8'd3, 8'd3});
    release_req();
    check_output("hit_nowb_idle", busy, 0);
    check_output("hit_nowb_data_held", rd_data, 3'b101);

    // Write miss without write-back: also no done.
    apply_stimulus(3'b010, 5'h0B, 5'h00, 3'b000, 6);
    check_output("wr_nowb_pulses", nd, 0);
    release_req();

    // Held request: one done only, then a one-cycle high rearms.
    apply_stimulus(3'b000, 5'h0B, 5'h00, 3'b000, 14);
    check_output("held_latency", fd, 3);
    check_output("held_pulses", nd, 1);
    req_n = 1'b1;
    @(posedge clock); #1;
    apply_stimulus(3'b000, 5'h0C, 5'h00, 3'b000, 8);
    check_output("rearm_latency", fd, 3);
    check_output("rearm_pulses", nd, 1);
    check_output("rearm_data", rd_data, 3'b101);
    release_req();
    check_output("miss_before_sat", miss_cnt, 5);
    check_output("sat_miss_2bit", miss_cnt_s, 3);
    check_output("sat_wb_2bit", wb_cnt_s, 3);

    // Reset in the middle of a write-back over RAM[0B] (currently 110).
    sig = 3'b011; wb_addr = 5'h0B; wb_data = 3'b001; fetch_addr = 5'h00;
    req_n = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_output("midwb_reset_outputs", {rd_data, done, busy, miss_cnt, wb_cnt}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    apply_stimulus(3'b000, 5'h0B, 5'h00, 3'b000, 8);
    check_output("midwb_no_accept_pulses", nd, 0);
    check_output("midwb_no_accept_busy", busy, 0);
    release_req();
    do_op("midwb_readback", 3'b000, 5'h0B, 5'h00, 3'b000, 3);
    check_output("midwb_ram_unchanged", rd_data, 3'b110);
    check_output("midwb_counts", {miss_cnt, wb_cnt}, {8'd1, 8'd0});

    // Saturation: five more clean misses.
    for (int k = 0; k < 5; k++) begin
      do_op("sat_read", 3'b000, 5'h0C, 5'h00, 3'b000, 3);
    end
    check_output("sat_miss_8bit", miss_cnt, 6);
    check_output("sat_miss_2bit_after_reset", miss_cnt_s, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
